// File: rtl/bip_debug_uart_if.sv
// UART-side debug controller for the BIP CPU: start-code gated run, halt detection, acc + cycle-count report.
// Optional single-step mode is compiled in when the DEBUG_STEP_EN macro is defined.
module bip_debug_uart_if #(
   parameter int unsigned                         CANT_BITS_OPCODE   = 5,
   parameter int unsigned                         CC_LENGTH          = 11,
   parameter int unsigned                         ACC_LENGTH         = 16,
   parameter int unsigned                         OUTPUT_WORD_LENGTH = 8,
   parameter logic [CANT_BITS_OPCODE-1:0]         HALT_OPCODE        = '0,
   parameter logic [OUTPUT_WORD_LENGTH-1:0]       START_CODE         = 8'hFF,
   parameter int unsigned                         START_COUNT        = 2
`ifdef DEBUG_STEP_EN
   ,
   parameter logic [OUTPUT_WORD_LENGTH-1:0]       STEP_CODE          = 8'hA5
`endif
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic                          i_rx_done,
   input  logic [OUTPUT_WORD_LENGTH-1:0] i_data_rx,
   input  logic [CANT_BITS_OPCODE-1:0]   i_opcode,
   input  logic [ACC_LENGTH-1:0]         i_acc,
   input  logic                          i_tx_done,
   output logic                          o_tx_start,
   output logic [OUTPUT_WORD_LENGTH-1:0] o_data_tx,
   output logic                          o_soft_reset,
   output logic                          o_enable
);

   localparam int unsigned W           = OUTPUT_WORD_LENGTH;
   localparam int unsigned ACC_BYTES   = (ACC_LENGTH + W - 1) / W;
   localparam int unsigned CC_BYTES    = (CC_LENGTH + W - 1) / W;
   localparam int unsigned ACC_BITS    = ACC_BYTES * W;
   localparam int unsigned CC_BITS     = CC_BYTES * W;
   localparam int unsigned TOTAL_BYTES = ACC_BYTES + CC_BYTES;
   localparam int unsigned SHIFT_BITS  = TOTAL_BYTES * W;
   localparam int unsigned BCNT_W      = (TOTAL_BYTES > 1) ? $clog2(TOTAL_BYTES) : 1;
   localparam int unsigned SCNT_W      = (START_COUNT > 1) ? $clog2(START_COUNT + 1) : 1;

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      LATCH,
      SEND
`ifdef DEBUG_STEP_EN
      ,
      STEP
`endif
   } state_t;

   state_t                  state;
   logic [SCNT_W-1:0]       start_cnt;
   logic [CC_LENGTH-1:0]    cc;
   logic [SHIFT_BITS-1:0]   shift;
   logic [BCNT_W-1:0]       byte_cnt;
`ifdef DEBUG_STEP_EN
   logic                    step_mode;
   logic                    step_halt;
`endif

   logic [CC_LENGTH-1:0]    cc_inc_c;
   logic [SHIFT_BITS-1:0]   packet_c;

   // Saturating cycle counter and the little-endian report image (acc bytes first, zero padded).
   assign cc_inc_c = (cc == '1) ? cc : cc + CC_LENGTH'(1);
   assign packet_c = {CC_BITS'(cc), ACC_BITS'(i_acc)};

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state        <= IDLE;
         start_cnt    <= '0;
         cc           <= '0;
         shift        <= '0;
         byte_cnt     <= '0;
         o_tx_start   <= 1'b0;
         o_data_tx    <= '0;
         o_soft_reset <= 1'b0;
         o_enable     <= 1'b0;
`ifdef DEBUG_STEP_EN
         step_mode    <= 1'b0;
         step_halt    <= 1'b0;
`endif
      end else begin
         o_tx_start <= 1'b0;
         case (state)
            IDLE: begin
               o_soft_reset <= 1'b0;
               o_enable     <= 1'b0;
               if (i_rx_done) begin
`ifdef DEBUG_STEP_EN
                  if (start_cnt == '0 && i_data_rx == STEP_CODE) begin
                     cc           <= '0;
                     o_soft_reset <= 1'b1;
                     step_mode    <= 1'b1;
                     state        <= STEP;
                  end else
`endif
                  if (i_data_rx == START_CODE) begin
                     if (start_cnt == SCNT_W'(START_COUNT - 1)) begin
                        start_cnt    <= '0;
                        cc           <= '0;
                        o_soft_reset <= 1'b1;
                        o_enable     <= 1'b1;
                        state        <= RUN;
`ifdef DEBUG_STEP_EN
                        step_mode    <= 1'b0;
`endif
                     end else begin
                        start_cnt <= start_cnt + SCNT_W'(1);
                     end
                  end else begin
                     start_cnt <= '0;
                  end
               end
            end

            // Every RUN cycle is an enabled CPU cycle, including the one that fetches HALT.
            RUN: begin
               cc <= cc_inc_c;
`ifdef DEBUG_STEP_EN
               step_halt <= (i_opcode == HALT_OPCODE);
               if (step_mode || i_opcode == HALT_OPCODE) begin
`else
               if (i_opcode == HALT_OPCODE) begin
`endif
                  o_enable <= 1'b0;
                  state    <= LATCH;
               end
            end

            LATCH: begin
               o_data_tx  <= packet_c[W-1:0];
               shift      <= packet_c >> W;
               byte_cnt   <= '0;
               o_tx_start <= 1'b1;
               state      <= SEND;
            end

            SEND: begin
               if (i_tx_done) begin
                  if (byte_cnt == BCNT_W'(TOTAL_BYTES - 1)) begin
                     start_cnt <= '0;
`ifdef DEBUG_STEP_EN
                     if (step_mode && !step_halt) begin
                        state <= STEP;
                     end else begin
                        state        <= IDLE;
                        o_soft_reset <= 1'b0;
                        step_mode    <= 1'b0;
                     end
`else
                     state        <= IDLE;
                     o_soft_reset <= 1'b0;
`endif
                  end else begin
                     byte_cnt   <= byte_cnt + BCNT_W'(1);
                     o_data_tx  <= shift[W-1:0];
                     shift      <= shift >> W;
                     o_tx_start <= 1'b1;
                  end
               end
            end

`ifdef DEBUG_STEP_EN
            // CPU held out of reset but frozen; each step byte grants exactly one enabled cycle.
            STEP: begin
               o_enable <= 1'b0;
               if (i_rx_done && i_data_rx == STEP_CODE) begin
                  o_enable <= 1'b1;
                  state    <= RUN;
               end
            end
`endif

            default: state <= IDLE;
         endcase
      end
   end

endmodule
